// File: rtl/mul_red_unpack_if.sv
// Result-bus interface for mul_red_unpack.
// master: producer/consumer side (testbench or surrounding datapath).
// slave:  the unpacker itself.
interface mul_red_unpack_if;
    logic        in_valid;
    logic        in_mode;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_coef;
    logic        out_lane;
    logic        out_last;
    logic        almost_full;
    logic        overflow;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  out_valid, out_coef, out_lane, out_last, almost_full, overflow
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output out_valid, out_coef, out_lane, out_last, almost_full, overflow
    );
endinterface

// File: rtl/mul_red_unpack.sv
// mul_red_unpack: consumer end of the modular multiply/reduce result bus.
// Buffers packed 24-bit result words (with their mode bit) in a FIFO and
// emits them one coefficient per handshake: Kyber words give lo then hi
// 12-bit lanes, Dilithium words give a single 23-bit coefficient.
// Optional feature: define CANON_SUB_EN to canonicalise every emitted
// coefficient into [0,q) with one conditional subtract.
module mul_red_unpack #(
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 5
) (
    input  logic           clk,
    input  logic           rst,
    mul_red_unpack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_EMIT_LO = 2'd1;
    localparam logic [1:0] ST_EMIT_HI = 2'd2;

    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_TWO   = CW'(2);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL = CW'(DEPTH - AFULL_MARGIN);

    // Kyber lane coefficient, zero-extended (optionally reduced mod 3329).
    function automatic logic [23:0] lane_coef(input logic [11:0] v);
`ifdef CANON_SUB_EN
        if (v >= 12'd3329) begin
            lane_coef = {12'd0, v - 12'd3329};
        end else begin
            lane_coef = {12'd0, v};
        end
`else
        lane_coef = {12'd0, v};
`endif
    endfunction

    // Dilithium coefficient, zero-extended (optionally reduced mod 8380417).
    function automatic logic [23:0] dil_coef(input logic [22:0] v);
`ifdef CANON_SUB_EN
        if (v >= 23'd8380417) begin
            dil_coef = {1'b0, v - 23'd8380417};
        end else begin
            dil_coef = {1'b0, v};
        end
`else
        dil_coef = {1'b0, v};
`endif
    endfunction

    // First coefficient of a FIFO entry {mode, data}; bit 23 is ignored for Dilithium.
    function automatic logic [23:0] first_coef(input logic [24:0] w);
        if (w[24]) begin
            first_coef = dil_coef(w[22:0]);
        end else begin
            first_coef = lane_coef(w[11:0]);
        end
    endfunction

    logic [24:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_ptr_inc_s;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic [23:0]   out_coef_q, out_coef_d;
    logic          out_lane_q, out_lane_d;
    logic          out_last_q, out_last_d;
    logic          almost_full_q, almost_full_d;
    logic          overflow_q, overflow_d;
    logic          xfer_s, pop_s, push_s;
    logic [24:0]   head_s, next_s, load_word_s;

    // FIFO bookkeeping: push/pop decisions, pointers, occupancy and flags.
    always_comb begin
        xfer_s       = out_valid_q & bus.out_ready;
        pop_s        = xfer_s & out_last_q;
        push_s       = bus.in_valid & ((count_q != CNT_FULL) | pop_s);
        rd_ptr_inc_s = rd_ptr_q + AW'(1);
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_inc_s;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        overflow_d    = overflow_q | (bus.in_valid & ~push_s);
        almost_full_d = (count_d >= CNT_AFULL);
    end

    // Select the word to load next: head when idle, the following entry when a pop is under way.
    always_comb begin
        head_s = mem_q[rd_ptr_q];
        next_s = mem_q[rd_ptr_inc_s];
        if (state_q == ST_EMPTY) begin
            load_word_s = head_s;
        end else begin
            load_word_s = next_s;
        end
    end

    // Output FSM: walk each buffered word one coefficient per transfer, no bubble between words.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_coef_d  = out_coef_q;
        out_lane_d  = out_lane_q;
        out_last_d  = out_last_q;
        case (state_q)
            ST_EMPTY: begin
                if (count_q != CNT_ZERO) begin
                    state_d     = ST_EMIT_LO;
                    out_valid_d = 1'b1;
                    out_coef_d  = first_coef(load_word_s);
                    out_lane_d  = 1'b0;
                    out_last_d  = load_word_s[24];
                end else begin
                    out_valid_d = 1'b0;
                    out_coef_d  = 24'd0;
                    out_lane_d  = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            ST_EMIT_LO, ST_EMIT_HI: begin
                if (pop_s) begin
                    // The popped word is still counted, so another word needs count >= 2.
                    if (count_q >= CNT_TWO) begin
                        state_d     = ST_EMIT_LO;
                        out_valid_d = 1'b1;
                        out_coef_d  = first_coef(load_word_s);
                        out_lane_d  = 1'b0;
                        out_last_d  = load_word_s[24];
                    end else begin
                        state_d     = ST_EMPTY;
                        out_valid_d = 1'b0;
                        out_coef_d  = 24'd0;
                        out_lane_d  = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end else if (xfer_s) begin
                    // Kyber low lane taken; the word is still at the head, emit its high lane.
                    state_d    = ST_EMIT_HI;
                    out_coef_d = lane_coef(head_s[23:12]);
                    out_lane_d = 1'b1;
                    out_last_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d     = ST_EMPTY;
                out_valid_d = 1'b0;
                out_coef_d  = 24'd0;
                out_lane_d  = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // FIFO storage: entries are not reset, occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {bus.in_mode, bus.in_data};
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            count_q       <= CNT_ZERO;
            state_q       <= ST_EMPTY;
            out_valid_q   <= 1'b0;
            out_coef_q    <= 24'd0;
            out_lane_q    <= 1'b0;
            out_last_q    <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_coef_q    <= out_coef_d;
            out_lane_q    <= out_lane_d;
            out_last_q    <= out_last_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_coef    = out_coef_q;
    assign bus.out_lane    = out_lane_q;
    assign bus.out_last    = out_last_q;
    assign bus.almost_full = almost_full_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_mul_red_unpack.sv
// Self-checking bench for mul_red_unpack: vector table, directed corner
// sequences and a randomized run against a coefficient-queue model.
`timescale 1ns/1ps
module tb_mul_red_unpack;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 5;

    logic clk = 1'b0;
    logic rst;
    mul_red_unpack_if bus();

    mul_red_unpack #(.DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [23:0] coef; logic lane; logic last; } coef_t;
    typedef struct { logic mode; logic [23:0] data; int n; logic [23:0] c0; logic [23:0] c1; } vec_t;

    int    total = 0;
    int    bad   = 0;
    coef_t expq[$];
    int    mcnt;
    logic  movf;
    vec_t  vt[7];

    function automatic logic [23:0] k_ref(input int v);
`ifdef CANON_SUB_EN
        if (v >= 3329) v = v - 3329;
`endif
        return 24'(v);
    endfunction

    function automatic logic [23:0] d_ref(input int v);
`ifdef CANON_SUB_EN
        if (v >= 8380417) v = v - 8380417;
`endif
        return 24'(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_mode  = 1'b0;
        bus.in_data  = 24'd0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic push(input logic mode, input logic [23:0] data);
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [23:0] c, input logic lane, input logic last);
        chk({name, " valid"}, 32'(bus.out_valid), 32'(1));
        chk({name, " coef"},  32'(bus.out_coef),  32'(c));
        chk({name, " lane"},  32'(bus.out_lane),  32'(lane));
        chk({name, " last"},  32'(bus.out_last),  32'(last));
    endtask

    // Expected coefficients of one word, derived from the packing rules.
    task automatic add_word(input logic mode, input logic [23:0] data);
        if (mode) begin
            expq.push_back('{d_ref(int'(data[22:0])), 1'b0, 1'b1});
        end else begin
            expq.push_back('{k_ref(int'(data[11:0])), 1'b0, 1'b0});
            expq.push_back('{k_ref(int'(data[23:12])), 1'b1, 1'b1});
        end
    endtask

    // One clock of the randomized run: sample, advance, update model, compare.
    task automatic rstep();
        logic pv, pr, iv, im, pop_e;
        logic [23:0] id;
        coef_t e;
        pv = bus.out_valid; pr = bus.out_ready;
        iv = bus.in_valid;  im = bus.in_mode; id = bus.in_data;
        tick();
        pop_e = 1'b0;
        if (pv && pr) begin
            if (expq.size() == 0) chk("rnd extra coef", 32'(pv), 32'(0));
            else begin
                e = expq.pop_front();
                pop_e = e.last;
            end
        end
        if (iv) begin
            if (mcnt < DEPTH || pop_e) begin
                mcnt++;
                add_word(im, id);
            end else begin
                movf = 1'b1;
            end
        end
        if (pop_e) mcnt--;
        chk("rnd afull", 32'(bus.almost_full), 32'(mcnt >= DEPTH - MARGIN));
        chk("rnd overflow", 32'(bus.overflow), 32'(movf));
        if (pv && !pr) chk("rnd hold valid", 32'(bus.out_valid), 32'(1));
        if (bus.out_valid) begin
            if (expq.size() == 0) chk("rnd spurious valid", 32'(bus.out_valid), 32'(0));
            else begin
                chk("rnd coef", 32'(bus.out_coef), 32'(expq[0].coef));
                chk("rnd lane", 32'(bus.out_lane), 32'(expq[0].lane));
                chk("rnd last", 32'(bus.out_last), 32'(expq[0].last));
            end
        end
    endtask

    initial begin
        vt[0] = '{1'b0, {12'd1234, 12'd56},   2, k_ref(56),      k_ref(1234)};
        vt[1] = '{1'b1, 24'h0F4240,           1, d_ref(1000000), 24'd0};
        vt[2] = '{1'b1, 24'h8F4240,           1, d_ref(1000000), 24'd0};
        vt[3] = '{1'b0, {12'd3330, 12'd3328}, 2, k_ref(3328),    k_ref(3330)};
        vt[4] = '{1'b1, 24'd8380418,          1, d_ref(8380418), 24'd0};
        vt[5] = '{1'b0, 24'd0,                2, k_ref(0),       k_ref(0)};
        vt[6] = '{1'b1, 24'h7FFFFF,           1, d_ref(8388607), 24'd0};

        // Reset state
        do_reset();
        chk("reset valid",  32'(bus.out_valid),   32'(0));
        chk("reset coef",   32'(bus.out_coef),    32'(0));
        chk("reset afull",  32'(bus.almost_full), 32'(0));
        chk("reset ovf",    32'(bus.overflow),    32'(0));

        // Single-word vectors, consumer always ready
        for (int i = 0; i < 7; i++) begin
            bus.out_ready = 1'b1;
            push(vt[i].mode, vt[i].data);
            tick();
            chk_out($sformatf("vec%0d c0", i), vt[i].c0, 1'b0, vt[i].n == 1);
            if (vt[i].n == 2) begin
                tick();
                chk_out($sformatf("vec%0d c1", i), vt[i].c1, 1'b1, 1'b1);
            end
            tick();
            chk($sformatf("vec%0d end", i), 32'(bus.out_valid), 32'(0));
        end

        // Backpressure: 3 mixed words held for 10 cycles, then drained without gaps
        do_reset();
        push(1'b0, {12'd11, 12'd22});
        push(1'b1, 24'd555);
        push(1'b0, {12'd33, 12'd44});
        for (int i = 0; i < 10; i++) begin
            chk_out("bp hold", 24'd22, 1'b0, 1'b0);
            tick();
        end
        chk_out("bp c0", 24'd22, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        tick(); chk_out("bp c1", 24'd11,  1'b1, 1'b1);
        tick(); chk_out("bp c2", 24'd555, 1'b0, 1'b1);
        tick(); chk_out("bp c3", 24'd44,  1'b0, 1'b0);
        tick(); chk_out("bp c4", 24'd33,  1'b1, 1'b1);
        tick(); chk("bp end", 32'(bus.out_valid), 32'(0));

        // Full: DEPTH+1 writes with no consumer, almost_full from count 3
        do_reset();
        for (int k = 1; k <= DEPTH + 1; k++) begin
            push(1'b1, 24'(k));
            chk($sformatf("full afull k=%0d", k), 32'(bus.almost_full), 32'(k >= 3));
            chk($sformatf("full ovf k=%0d", k), 32'(bus.overflow), 32'(k > DEPTH));
        end

        // Pop and push at the same edge while full: accepted, no overflow
        do_reset();
        for (int k = 0; k < DEPTH; k++) push(1'b1, 24'(100 + k));
        bus.out_ready = 1'b1;
        push(1'b1, 24'd200);
        bus.out_ready = 1'b0;
        chk("popush ovf", 32'(bus.overflow), 32'(0));
        chk("popush afull", 32'(bus.almost_full), 32'(1));
        chk_out("popush next", 24'd101, 1'b0, 1'b1);
        push(1'b1, 24'd201);
        chk("popush still full", 32'(bus.overflow), 32'(1));

        // Reset mid-stream while emitting a high lane with 4 words buffered
        do_reset();
        for (int k = 0; k < 4; k++) push(1'b0, {12'(k + 1), 12'(k + 10)});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk_out("mid hi", 24'd1, 1'b1, 1'b1);
        rst = 1'b0;
        tick();
        chk("mid valid", 32'(bus.out_valid),   32'(0));
        chk("mid ovf",   32'(bus.overflow),    32'(0));
        chk("mid afull", 32'(bus.almost_full), 32'(0));
        rst = 1'b1;
        tick(); tick(); tick();
        chk("mid discard", 32'(bus.out_valid), 32'(0));

        // Randomized mixed traffic against the queue model
        do_reset();
        expq.delete();
        mcnt = 0;
        movf = 1'b0;
        for (int c = 0; c < 800; c++) begin
            bus.in_valid = ($urandom_range(0, 9) < 6);
            bus.in_mode  = 1'($urandom_range(0, 1));
            if (bus.in_mode)
                bus.in_data = {1'($urandom_range(0, 1)), 23'($urandom_range(0, 8380416))};
            else
                bus.in_data = {12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328))};
            if (((c / 50) % 2) == 1) bus.out_ready = ($urandom_range(0, 9) < 9);
            else bus.out_ready = ($urandom_range(0, 9) < 3);
            rstep();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (expq.size() == 0 && !bus.out_valid) break;
            rstep();
        end
        chk("drain queue", 32'(expq.size()), 32'(0));
        chk("drain valid", 32'(bus.out_valid), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
